// File: rtl/multi_door_visitor_counter.sv
`default_nettype none
// ============================================================================
//  Module   : multi_door_visitor_counter
//  Brief    : N-door IR visitor counter. Each door has a two-flop sensor
//             synchroniser and a direction FSM with an inactivity timeout; a
//             shared saturating occupancy counter merges all doors' events
//             each cycle. Also keeps a lifetime entry total and full/empty
//             flags.
//  Revision : 1.0 - initial multi-door release
// ============================================================================
module multi_door_visitor_counter #(
    parameter int NUM_DOORS = 2,
    parameter int COUNT_W   = 8,
    parameter int TOTAL_W   = 16,
    parameter int MAX_OCC   = 200,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [NUM_DOORS-1:0] ir_sensor1,
    input  logic [NUM_DOORS-1:0] ir_sensor2,
    output logic [COUNT_W-1:0]   curr_visitor,
    output logic [TOTAL_W-1:0]   total_visitors,
    output logic [NUM_DOORS-1:0] entry_pulse,
    output logic [NUM_DOORS-1:0] exit_pulse,
    output logic [NUM_DOORS-1:0] abort_pulse,
    output logic                 full,
    output logic                 empty
);

    // Door FSM encoding
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_IN1  = 3'd1;
    localparam logic [2:0] c_IN2  = 3'd2;
    localparam logic [2:0] c_IN3  = 3'd3;
    localparam logic [2:0] c_OUT1 = 3'd4;
    localparam logic [2:0] c_OUT2 = 3'd5;
    localparam logic [2:0] c_OUT3 = 3'd6;

    localparam int                 c_TMR_W   = $clog2(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE = c_TMR_W'(1);

    // Synchroniser flops
    logic [NUM_DOORS-1:0] r_s1_meta, r_s1_sync;
    logic [NUM_DOORS-1:0] r_s2_meta, r_s2_sync;

    // Per-door combinational events
    logic [NUM_DOORS-1:0] w_entry, w_exit, w_abort;

    // Shared registered state
    logic [COUNT_W-1:0]   r_curr;
    logic [TOTAL_W-1:0]   r_total;
    logic [NUM_DOORS-1:0] r_entry_pulse, r_exit_pulse, r_abort_pulse;
    logic                 r_full, r_empty;

    // Counter arithmetic
    logic [3:0]           w_ent_cnt, w_ext_cnt;
    logic [COUNT_W+3:0]   w_occ_sum;
    logic [COUNT_W-1:0]   w_occ_next;
    logic [TOTAL_W:0]     w_tot_sum;
    logic [TOTAL_W-1:0]   w_tot_next;

    function automatic logic [3:0] f_popcount(input logic [NUM_DOORS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_DOORS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Two-flop synchronisers; deliberately untouched by clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_meta <= '0;
            r_s1_sync <= '0;
            r_s2_meta <= '0;
            r_s2_sync <= '0;
        end else begin
            r_s1_meta <= ir_sensor1;
            r_s1_sync <= r_s1_meta;
            r_s2_meta <= ir_sensor2;
            r_s2_sync <= r_s2_meta;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DOORS; g++) begin : g_door
            logic [2:0]         r_state;
            logic [2:0]         w_nxt;
            logic [c_TMR_W-1:0] r_timer;
            logic               w_ent, w_ext, w_tmo;
            logic [1:0]         w_s;

            assign w_s = {r_s1_sync[g], r_s2_sync[g]};

            // Direction decode; OUT states mirror IN states with sensors swapped
            always_comb begin
                w_nxt = r_state;
                w_ent = 1'b0;
                w_ext = 1'b0;
                case (r_state)
                    c_IDLE: begin
                        if (w_s == 2'b10)      w_nxt = c_IN1;
                        else if (w_s == 2'b01) w_nxt = c_OUT1;
                    end
                    c_IN1: begin
                        if (w_s == 2'b11)      w_nxt = c_IN2;
                        else if (w_s == 2'b01) w_nxt = c_IN3;
                        else if (w_s == 2'b00) w_nxt = c_IDLE;
                    end
                    c_IN2: begin
                        if (w_s == 2'b01)      w_nxt = c_IN3;
                        else if (w_s == 2'b10) w_nxt = c_IN1;
                    end
                    c_IN3: begin
                        if (w_s == 2'b00) begin
                            w_nxt = c_IDLE;
                            w_ent = 1'b1;
                        end else if (w_s == 2'b11) w_nxt = c_IN2;
                        else if (w_s == 2'b10)     w_nxt = c_IN1;
                    end
                    c_OUT1: begin
                        if (w_s == 2'b11)      w_nxt = c_OUT2;
                        else if (w_s == 2'b10) w_nxt = c_OUT3;
                        else if (w_s == 2'b00) w_nxt = c_IDLE;
                    end
                    c_OUT2: begin
                        if (w_s == 2'b10)      w_nxt = c_OUT3;
                        else if (w_s == 2'b01) w_nxt = c_OUT1;
                    end
                    c_OUT3: begin
                        if (w_s == 2'b00) begin
                            w_nxt = c_IDLE;
                            w_ext = 1'b1;
                        end else if (w_s == 2'b11) w_nxt = c_OUT2;
                        else if (w_s == 2'b01)     w_nxt = c_OUT1;
                    end
                    default: w_nxt = c_IDLE;
                endcase
            end

            // A stalled non-IDLE door gives up once its timer has run out
            assign w_tmo = (r_state != c_IDLE) && (w_nxt == r_state) &&
                           (r_timer == c_TMR_MAX);

            // State register and inactivity timer
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= c_IDLE;
                    r_timer <= '0;
                end else if (clear || w_tmo) begin
                    r_state <= c_IDLE;
                    r_timer <= '0;
                end else begin
                    r_state <= w_nxt;
                    if (r_state == c_IDLE || w_nxt != r_state) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end
            end

            assign w_entry[g] = w_ent;
            assign w_exit[g]  = w_ext;
            assign w_abort[g] = w_tmo;
        end
    endgenerate

    // Net occupancy change in a 4-bit-wider two's complement field so that
    // underflow shows up in the top bit and overflow in the guard bits.
    always_comb begin
        w_ent_cnt = f_popcount(w_entry);
        w_ext_cnt = f_popcount(w_exit);
        w_occ_sum = {4'b0000, r_curr} + {{COUNT_W{1'b0}}, w_ent_cnt}
                  - {{COUNT_W{1'b0}}, w_ext_cnt};
        if (w_occ_sum[COUNT_W+3]) begin
            w_occ_next = '0;
        end else if (|w_occ_sum[COUNT_W+2:COUNT_W]) begin
            w_occ_next = '1;
        end else begin
            w_occ_next = w_occ_sum[COUNT_W-1:0];
        end
        w_tot_sum = {1'b0, r_total} + {{(TOTAL_W-3){1'b0}}, w_ent_cnt};
        w_tot_next = w_tot_sum[TOTAL_W] ? '1 : w_tot_sum[TOTAL_W-1:0];
    end

    // Counters, status flags and event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_curr        <= '0;
            r_total       <= '0;
            r_entry_pulse <= '0;
            r_exit_pulse  <= '0;
            r_abort_pulse <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
        end else if (clear) begin
            r_curr        <= '0;
            r_total       <= '0;
            r_entry_pulse <= '0;
            r_exit_pulse  <= '0;
            r_abort_pulse <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
        end else begin
            r_curr        <= w_occ_next;
            r_total       <= w_tot_next;
            r_entry_pulse <= w_entry;
            r_exit_pulse  <= w_exit;
            r_abort_pulse <= w_abort;
            r_full        <= (w_occ_next >= COUNT_W'(MAX_OCC));
            r_empty       <= (w_occ_next == '0);
        end
    end

    assign curr_visitor   = r_curr;
    assign total_visitors = r_total;
    assign entry_pulse    = r_entry_pulse;
    assign exit_pulse     = r_exit_pulse;
    assign abort_pulse    = r_abort_pulse;
    assign full           = r_full;
    assign empty          = r_empty;

endmodule
`default_nettype wire

// File: doc/multi_door_visitor_counter.md
Name: multi_door_visitor_counter

Overview:
Parametrised successor to the single-door visitor counter for the smart home automation top level. It tracks N doorways, each fitted with an outer IR sensor (ir_sensor1) and an inner IR sensor (ir_sensor2). A per-door direction FSM decodes entries and exits, and a shared occupancy counter combines events from all doors in the same cycle. The block adds saturation, a capacity flag, a lifetime entry total, abort detection on timeout, and a synchronous clear.

Parameters:
NUM_DOORS, 2, number of doorways (1..8).
COUNT_W, 8, width of curr_visitor.
TOTAL_W, 16, width of total_visitors.
MAX_OCC, 200, capacity threshold for full; must be ≤ 2^COUNT_W-1.
TIMEOUT, 1000, cycles a door FSM may remain in a non-IDLE state with no state change before aborting; ≥ 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
clear  input  1  synchronous clear of counts and FSMs.
ir_sensor1  input  NUM_DOORS  outer sensor per door, 1 = beam broken, asynchronous.
ir_sensor2  input  NUM_DOORS  inner sensor per door, 1 = beam broken, asynchronous.
curr_visitor  output  COUNT_W  current occupancy.
total_visitors  output  TOTAL_W  lifetime completed entries.
entry_pulse  output  NUM_DOORS  1-cycle pulse per completed entry.
exit_pulse  output  NUM_DOORS  1-cycle pulse per completed exit.
abort_pulse  output  NUM_DOORS  1-cycle pulse when a door FSM times out.
full  output  1  curr_visitor ≥ MAX_OCC.
empty  output  1  curr_visitor == 0.

Behaviour:
- Reset (reset=0, asynchronous): all counts 0, all pulses 0, all FSMs IDLE, timers 0, sync flops 0; full=0, empty=1.
- Synchronizer: each sensor bit passes through 2 flops before reaching its FSM. Below, s1/s2 denote the synchronized values.
- Door FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3. Unlisted (s1,s2) combinations hold the current state.
  - IDLE: (1,0)→IN1; (0,1)→OUT1; (1,1) or (0,0) stay IDLE.
  - IN1: (1,1)→IN2; (0,1)→IN3; (0,0)→IDLE with no event (visitor backed out).
  - IN2: (0,1)→IN3; (1,0)→IN1.
  - IN3: (0,0)→IDLE and entry event; (1,1)→IN2; (1,0)→IN1.
  - OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with s1 and s2 swapped; OUT3 (0,0)→IDLE and exit event.
- Timeout:
  - Per-door timer clears on every state change and whenever the FSM is in IDLE.
  - It increments each cycle the FSM stays in a non-IDLE state.
  - When the timer reaches TIMEOUT-1 with no transition this cycle: FSM→IDLE, abort_pulse for 1 cycle, no count change.
- Latency: if the final (0,0) is sampled by the first sync flop at edge k, then after edge k+2 entry_pulse/exit_pulse is high for exactly 1 cycle and curr_visitor already reflects the event.
- Occupancy arithmetic:
  - next = curr + popcount(entry events) − popcount(exit events), computed at COUNT_W+4 signed width.
  - Clamp the result to the range [0, 2^COUNT_W−1].
  - Exits at 0 are ignored (their exit_pulse still fires).
  - Simultaneous entry and exit on different doors net out in one cycle.
- total_visitors: adds popcount(entry events) each cycle and saturates at 2^TOTAL_W−1. It is not decremented by exits.
- full/empty: registered, consistent with curr_visitor in the same cycle. Entries are still counted when full; full is advisory (drives the door-lock logic upstream).
- clear=1: at the next edge curr_visitor=0, total_visitors=0, FSMs→IDLE, timers=0, pulses=0. Events completing in the clear cycle are discarded. Synchronizers are not cleared.
- Reset asserted mid-sequence: immediate return to the reset state. After release a door needs a fresh (1,0) or (0,1) start.

Test Plan:
Use NUM_DOORS=2, COUNT_W=8, MAX_OCC=4, TIMEOUT=16 throughout.
1. Door0 (1,0)→(0,1)→(0,0), 10 cycles per step, repeated 4 times → entry_pulse[0] 4 times, curr_visitor=4, total_visitors=4, full=1.
2. Door0 (1,0)→(1,1)→(0,1)→(0,0), then door1 (0,1)→(1,1)→(1,0)→(0,0) → 1 entry then 1 exit; curr_visitor ends at the previous value.
3. Door0 (1,0)→(0,0) back-out; door1 (0,1) held 20 cycles → no entry pulse; abort_pulse[1] once, 16 cycles after entering OUT1; count unchanged.
4. Both doors complete in the same cycle (door0 entry, door1 exit) from count=2 → entry_pulse=01, exit_pulse=10 in the same cycle; curr_visitor stays 2.
5. Exit sequence at curr_visitor=0 → exit_pulse fires, curr_visitor=0, empty=1. Force count to 255 and enter on both doors → curr_visitor=255.
6. reset=0 mid-IN2 → all outputs at reset values immediately. clear=1 at count=3 → curr_visitor=0 and total_visitors=0 at the next edge.
